ram_cycle_seq: RTL and testbench
================================

Name: ram_cycle_seq

Overview:
Synchronous sequencer for the expansion SRAM. Samples the asynchronous 68000 bus strobes on CLK and drives the SRAM output-enable and byte-lane write strobes with a programmable number of wait states. Returns DTACK (positive logic) for each accepted cycle and suppresses writes to the write-protected maprom shadow. Sits between the address decoder that produces ram_sel and the SRAM chip pins.

Parameters:
SYNC_STAGES, 2, flops in each strobe synchronizer (legal 2..3)
WAIT_STATES, 1, extra CLK cycles the SRAM strobe is held before DTACK (legal 0..7)
TIMEOUT, 15, max CLK cycles in ARM waiting for a data strobe before abandoning (legal 1..255)

Ports:
CLK  in  1  bus clock; all state changes on rising edge
RST  in  1  synchronous reset, active-high
_AS  in  1  68000 address strobe, async, active-low
_UDS  in  1  upper data strobe, async, active-low
_LDS  in  1  lower data strobe, async, active-low
RW  in  1  1=read, 0=write; stable while _AS low
ram_sel  in  1  decoded SRAM select; stable while _AS low
wr_protect  in  1  address is in the protected maprom region
_RAM_OE  out  1  SRAM output enable, active-low
_RAM_WE_U  out  1  SRAM upper-byte write enable, active-low
_RAM_WE_L  out  1  SRAM lower-byte write enable, active-low
DTACK  out  1  data acknowledge, positive logic
busy  out  1  high in every state except IDLE
wp_hit  out  1  one-cycle pulse when a protected write is swallowed

Behaviour:
- Synchronizers: as_s, uds_s, lds_s = inputs delayed by SYNC_STAGES flops. ds_s = !uds_s | !lds_s, meaning a strobe is asserted. RW, ram_sel and wr_protect are not synchronized. They are sampled only where stated below.
- Every output is a registered function of state plus latched fields. Reset values: _RAM_OE=1, _RAM_WE_U=1, _RAM_WE_L=1, DTACK=0, busy=0, wp_hit=0, state IDLE, counters 0.
- IDLE: if !as_s & ram_sel, go to ARM and clear the timeout counter. Otherwise stay.
- ARM: as_s high (aborted cycle) takes priority; go to IDLE with no strobe. Else, if ds_s, latch rw_l=RW, u_l=!uds_s, l_l=!lds_s, wp_l=wr_protect. Then go to STROBE with wcnt=WAIT_STATES. Else increment the timeout counter; when it equals TIMEOUT, go to IDLE with no strobe and no DTACK. Counter width is ceil(log2(TIMEOUT+1)).
- STROBE: for a read, _RAM_OE=0. For a write with !wp_l, _RAM_WE_U=!u_l and _RAM_WE_L=!l_l. For a write with wp_l, both WE stay 1. If wcnt==0, go to ACK. Else decrement. STROBE therefore lasts WAIT_STATES+1 cycles.
- wp_hit: high for exactly the first STROBE cycle of a protected write.
- ACK: DTACK=1 and strobes are held as in STROBE. If as_s high, go to IDLE. Else if both data strobes are released (!ds_s), go to END.
- END: all strobes high and DTACK=0. Go to IDLE when as_s is high.
- Latency: if ds_s is first seen in ARM at cycle t, strobes go low at t+1 and DTACK rises at t+WAIT_STATES+2.
  - If as_s and ds_s are asserted together in IDLE, the path still goes IDLE to ARM to STROBE (fixed one-cycle cost).
  - Pin-to-DTACK for a read with WAIT_STATES=1, SYNC_STAGES=2, _AS and _UDS falling together: 6 CLK.
- Latched values are authoritative. Changes to RW, ram_sel, wr_protect or the strobe lane pattern after ARM are ignored until IDLE.
- DTACK is deasserted no later than the cycle after the strobes are seen released. The bus must never see DTACK in a later cycle.
- RST high on any edge forces IDLE and reset values on that edge, including mid-STROBE. Any in-flight write strobe is cut.
- After reset, a bus cycle already in progress (as_s low) is not serviced. It is ignored until as_s returns high and a new IDLE entry occurs. This is enforced by IDLE requiring a seen-high as_s since reset, tracked by a flag.

Test Plan:
- Word read, WAIT_STATES=1, ram_sel=1, RW=1, _AS/_UDS/_LDS fall at cycle 0 -> _RAM_OE low cycles 4..7, DTACK high from cycle 6 until 1 cycle after strobes seen high; WE stay 1; busy high throughout.
- Byte write, lower lane only (_LDS low, _UDS high), wr_protect=0 -> _RAM_WE_L low for WAIT_STATES+1 cycles then through ACK; _RAM_WE_U stays 1; _RAM_OE stays 1.
- Protected write, wr_protect=1, RW=0 -> both WE stay 1, wp_hit pulses exactly one cycle, DTACK still asserted at the normal cycle.
- _AS low with no data strobe for >TIMEOUT=15 cycles -> return to IDLE after 15 ARM cycles, no strobe, no DTACK. Next cycle after _AS rises/falls is serviced normally.
- RST pulse while in STROBE of a write -> WE high and DTACK 0 on the same edge. The ongoing bus cycle gets no DTACK. The next full cycle after _AS negates completes normally.
- ram_sel=0 with _AS low -> stays IDLE, all outputs at reset values. Sweep WAIT_STATES 0 and 7 -> DTACK at t+2 and t+9 respectively.

Source files
------------

// File: rtl/ram_cycle_seq.sv
// Purpose: synchronous SRAM cycle sequencer behind the 68000 bus decoder.
// Latency: DTACK rises WAIT_STATES+2 CLK after a data strobe is first seen synchronized.
// Backpressure: the bus is held off by withholding DTACK; an idle strobe times out after TIMEOUT CLK.
//
// Ports:
//   CLK, RST              clock and synchronous active-high reset
//   _AS, _UDS, _LDS       asynchronous 68000 strobes (active-low), synchronized here
//   RW, ram_sel           bus direction and decoded select, sampled unsynchronized
//   wr_protect            target lies in the write-protected maprom shadow
//   _RAM_OE, _RAM_WE_U/L  SRAM pin strobes (active-low, registered)
//   DTACK                 data acknowledge, positive logic (registered)
//   busy                  sequencer is not idle
//   wp_hit                one-cycle pulse when a protected write is swallowed
module ram_cycle_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic _AS,
    input  logic _UDS,
    input  logic _LDS,
    input  logic RW,
    input  logic ram_sel,
    input  logic wr_protect,
    output logic _RAM_OE,
    output logic _RAM_WE_U,
    output logic _RAM_WE_L,
    output logic DTACK,
    output logic busy,
    output logic wp_hit
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
    localparam logic [2:0]    WAIT_V    = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_STROBE,
        ST_ACK,
        ST_END
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
    logic [SYNC_STAGES-1:0] uds_sync_q, uds_sync_d;
    logic [SYNC_STAGES-1:0] lds_sync_q, lds_sync_d;
    logic [TW-1:0]          tcnt_q, tcnt_d, tcnt_inc;
    logic [2:0]             wcnt_q, wcnt_d;
    logic                   rw_l_q, rw_l_d;
    logic                   u_l_q, u_l_d;
    logic                   l_l_q, l_l_d;
    logic                   wp_l_q, wp_l_d;
    logic                   seen_q, seen_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_u_n_q, we_u_n_d;
    logic                   we_l_n_q, we_l_n_d;
    logic                   dtack_q, dtack_d;
    logic                   busy_q, busy_d;
    logic                   wp_hit_q, wp_hit_d;

    logic as_s, uds_s, lds_s, ds_s, strobing;

    assign as_s  = as_sync_q[SYNC_STAGES-1];
    assign uds_s = uds_sync_q[SYNC_STAGES-1];
    assign lds_s = lds_sync_q[SYNC_STAGES-1];
    assign ds_s  = !uds_s || !lds_s;

    always_comb begin
        state_d    = state_q;
        as_sync_d  = {as_sync_q[SYNC_STAGES-2:0], _AS};
        uds_sync_d = {uds_sync_q[SYNC_STAGES-2:0], _UDS};
        lds_sync_d = {lds_sync_q[SYNC_STAGES-2:0], _LDS};
        tcnt_d     = tcnt_q;
        tcnt_inc   = tcnt_q + 1'b1;
        wcnt_d     = wcnt_q;
        rw_l_d     = rw_l_q;
        u_l_d      = u_l_q;
        l_l_d      = l_l_q;
        wp_l_d     = wp_l_q;
        // A cycle is only eligible once _AS has been observed high, so a
        // cycle already under way at reset (or at a timeout) is never picked up.
        seen_d     = seen_q || as_s;

        case (state_q)
            ST_IDLE: begin
                if (!as_s && ram_sel && seen_q) begin
                    state_d = ST_ARM;
                    tcnt_d  = '0;
                end
            end
            ST_ARM: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (ds_s) begin
                    rw_l_d  = RW;
                    u_l_d   = !uds_s;
                    l_l_d   = !lds_s;
                    wp_l_d  = wr_protect;
                    wcnt_d  = WAIT_V;
                    state_d = ST_STROBE;
                end else begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == TIMEOUT_V) begin
                        // Abandoned cycle: do not re-arm on the same _AS assertion.
                        state_d = ST_IDLE;
                        seen_d  = 1'b0;
                    end
                end
            end
            ST_STROBE: begin
                if (wcnt_q == 3'd0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end else if (!ds_s) begin
                    state_d = ST_END;
                end
            end
            ST_END: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so pins change on the
        // same edge as the state they belong to.
        strobing = (state_d == ST_STROBE) || (state_d == ST_ACK);
        oe_n_d   = !(strobing && rw_l_d);
        we_u_n_d = !(strobing && !rw_l_d && !wp_l_d && u_l_d);
        we_l_n_d = !(strobing && !rw_l_d && !wp_l_d && l_l_d);
        dtack_d  = (state_d == ST_ACK);
        busy_d   = (state_d != ST_IDLE);
        wp_hit_d = (state_q == ST_ARM) && (state_d == ST_STROBE) && !rw_l_d && wp_l_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            // _AS synchronizer resets to "asserted" so it cannot fake a
            // seen-high sample before the real pin value has propagated.
            as_sync_q  <= '0;
            uds_sync_q <= '1;
            lds_sync_q <= '1;
            tcnt_q     <= '0;
            wcnt_q     <= '0;
            rw_l_q     <= 1'b0;
            u_l_q      <= 1'b0;
            l_l_q      <= 1'b0;
            wp_l_q     <= 1'b0;
            seen_q     <= 1'b0;
            oe_n_q     <= 1'b1;
            we_u_n_q   <= 1'b1;
            we_l_n_q   <= 1'b1;
            dtack_q    <= 1'b0;
            busy_q     <= 1'b0;
            wp_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            as_sync_q  <= as_sync_d;
            uds_sync_q <= uds_sync_d;
            lds_sync_q <= lds_sync_d;
            tcnt_q     <= tcnt_d;
            wcnt_q     <= wcnt_d;
            rw_l_q     <= rw_l_d;
            u_l_q      <= u_l_d;
            l_l_q      <= l_l_d;
            wp_l_q     <= wp_l_d;
            seen_q     <= seen_d;
            oe_n_q     <= oe_n_d;
            we_u_n_q   <= we_u_n_d;
            we_l_n_q   <= we_l_n_d;
            dtack_q    <= dtack_d;
            busy_q     <= busy_d;
            wp_hit_q   <= wp_hit_d;
        end
    end

    assign _RAM_OE   = oe_n_q;
    assign _RAM_WE_U = we_u_n_q;
    assign _RAM_WE_L = we_l_n_q;
    assign DTACK     = dtack_q;
    assign busy      = busy_q;
    assign wp_hit    = wp_hit_q;

endmodule

// File: tb/tb_ram_cycle_seq.sv
// Purpose: bench for ram_cycle_seq at WAIT_STATES 1, 0 and 7 sharing one bus.
// Latency: expected waveforms are derived per cycle from pin timing.
// Backpressure: n/a (bench drives a pre-planned bus cycle).
module tb_ram_cycle_seq;

    localparam int S  = 2;
    localparam int TO = 15;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, as_n, uds_n, lds_n, rw, sel, wp;
    logic oe_n[NI], weu_n[NI], wel_n[NI], dtack[NI], busy[NI], wph[NI];

    int n_tests = 0;
    int n_fail  = 0;

    ram_cycle_seq #(.SYNC_STAGES(S), .WAIT_STATES(1), .TIMEOUT(TO)) u_dut_w1 (
        .CLK(clk), .RST(rst), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw),
        .ram_sel(sel), .wr_protect(wp), ._RAM_OE(oe_n[0]), ._RAM_WE_U(weu_n[0]),
        ._RAM_WE_L(wel_n[0]), .DTACK(dtack[0]), .busy(busy[0]), .wp_hit(wph[0]));

    ram_cycle_seq #(.SYNC_STAGES(S), .WAIT_STATES(0), .TIMEOUT(TO)) u_dut_w0 (
        .CLK(clk), .RST(rst), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw),
        .ram_sel(sel), .wr_protect(wp), ._RAM_OE(oe_n[1]), ._RAM_WE_U(weu_n[1]),
        ._RAM_WE_L(wel_n[1]), .DTACK(dtack[1]), .busy(busy[1]), .wp_hit(wph[1]));

    ram_cycle_seq #(.SYNC_STAGES(S), .WAIT_STATES(7), .TIMEOUT(TO)) u_dut_w7 (
        .CLK(clk), .RST(rst), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw),
        .ram_sel(sel), .wr_protect(wp), ._RAM_OE(oe_n[2]), ._RAM_WE_U(weu_n[2]),
        ._RAM_WE_L(wel_n[2]), .DTACK(dtack[2]), .busy(busy[2]), .wp_hit(wph[2]));

    function automatic int ws(int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 7;
        endcase
    endfunction

    task automatic check_eq(string tag, logic got, logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_all(int i, string where, logic e_oe, logic e_weu, logic e_wel,
                             logic e_dt, logic e_bz, logic e_hit);
        check_eq($sformatf("oe_n w%0d %s", ws(i), where), oe_n[i], e_oe);
        check_eq($sformatf("we_u_n w%0d %s", ws(i), where), weu_n[i], e_weu);
        check_eq($sformatf("we_l_n w%0d %s", ws(i), where), wel_n[i], e_wel);
        check_eq($sformatf("dtack w%0d %s", ws(i), where), dtack[i], e_dt);
        check_eq($sformatf("busy w%0d %s", ws(i), where), busy[i], e_bz);
        check_eq($sformatf("wp_hit w%0d %s", ws(i), where), wph[i], e_hit);
    endtask

    // mode 0: normal cycle, 1: ram_sel low, 2: no data strobe (timeout),
    // 3: reset pulse in the first strobe cycle.
    // Pins fall at cycle 0 (_AS) and d (data strobes), strobes rise at r, _AS at e.
    task automatic run_txn(int mode, int d, int r, int e, bit t_rw, bit t_u, bit t_l,
                           bit t_wp, bit flip);
        int arm, t, len;
        int ack_s[NI], c0[NI], idle_at[NI];
        bit act, dt, bz, hit;
        arm = S + 1;
        if (mode == 2) begin
            d = 1000;
            r = 1000;
            e = arm + TO + 4;
        end
        t   = (d + S > arm) ? d + S : arm;
        len = e + S + 6;
        for (int i = 0; i < NI; i++) begin
            ack_s[i]   = t + ws(i) + 2;
            c0[i]      = (r + S > ack_s[i]) ? r + S : ack_s[i];
            idle_at[i] = ((c0[i] > e + S) ? c0[i] : e + S) + 1;
            if (mode == 0 && idle_at[i] + 4 > len) len = idle_at[i] + 4;
        end
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            as_n  = !(c < e);
            uds_n = !(t_u && c >= d && c < r);
            lds_n = !(t_l && c >= d && c < r);
            rw    = (flip && c > t) ? !t_rw : t_rw;
            wp    = (flip && c > t) ? !t_wp : t_wp;
            sel   = (mode == 1) ? 1'b0 : !(flip && c > t);
            rst   = (mode == 3 && c == t + 1);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                act = 0; dt = 0; bz = 0; hit = 0;
                if (mode == 0 || mode == 3) begin
                    act = (c >= t + 1) && (c <= c0[i]);
                    dt  = (c >= ack_s[i]) && (c <= c0[i]);
                    bz  = (c >= arm) && (c < idle_at[i]);
                    hit = (c == t + 1) && !t_rw && t_wp;
                    if (mode == 3 && c > t + 1) begin
                        act = 0; dt = 0; bz = 0; hit = 0;
                    end
                end else if (mode == 2) begin
                    bz = (c >= arm) && (c < arm + TO);
                end
                check_all(i, $sformatf("m%0d c%0d", mode, c),
                          !(act && t_rw),
                          !(act && !t_rw && !t_wp && t_u),
                          !(act && !t_rw && !t_wp && t_l),
                          dt, bz, hit);
            end
        end
    endtask

    initial begin
        int mode, d, r, e;
        bit b_rw, b_u, b_l, b_wp, b_fl;
        rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        rw = 1'b1; sel = 1'b1; wp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_all(i, "reset", 1, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (S + 3) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) check_all(i, "post-reset", 1, 1, 1, 0, 0, 0);
        end

        // word read, lower-byte write, protected write, timeout, reset mid-strobe, unselected
        run_txn(0, 0, 6, 6, 1, 1, 1, 0, 0);
        run_txn(0, 1, 9, 10, 0, 0, 1, 0, 0);
        run_txn(0, 0, 8, 9, 0, 1, 1, 1, 0);
        run_txn(2, 0, 0, 0, 1, 0, 0, 0, 0);
        run_txn(3, 0, 10, 12, 0, 1, 1, 0, 0);
        run_txn(1, 0, 6, 8, 1, 1, 1, 0, 0);
        run_txn(0, 0, 6, 7, 1, 1, 1, 0, 1);

        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(9);
            mode = (mode < 7) ? 0 : mode - 6;
            d    = $urandom_range(3);
            r    = d + 4 + $urandom_range(9);
            e    = r + $urandom_range(3);
            b_rw = 1'($urandom);
            b_u  = 1'($urandom);
            b_l  = 1'($urandom);
            if (!b_u && !b_l) b_l = 1'b1;
            b_wp = 1'($urandom);
            b_fl = 1'($urandom);
            run_txn(mode, d, r, e, b_rw, b_u, b_l, b_wp, b_fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
